// File: rtl/icache_if.sv
// icache_if: groups the fetch-side and physical-memory-side signals of the
// instruction cache into one bundle.
//   mem_address  [15:0]  fetch address (PC)               master -> cache
//   mem_read             fetch request, held until resp   master -> cache
//   mem_rdata    [15:0]  returned instruction word        cache  -> master
//   mem_resp             fetch complete this cycle        cache  -> master
//   pmem_address [15:0]  line-aligned fill address        cache  -> master
//   pmem_read            line-fill request                cache  -> master
//   pmem_rdata  [127:0]  fill line data                   master -> cache
//   pmem_resp            fill data valid (1-cycle pulse)  master -> cache
// "slave" is the cache's view; "master" is the view of whatever sits around
// it (fetch stage plus backing memory).
interface icache_if;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read
  );

  modport master (
    output mem_address, mem_read, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read
  );
endinterface

// File: rtl/icache.sv
// icache: 8-line x 128-bit direct-mapped read-only instruction cache.
// Hits answer combinationally in the same cycle; a miss fetches the whole
// line from physical memory and the request then hits in the first IDLE
// cycle after the fill.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-high reset (clears valid bits and the FSM)
//   bus    icache_if.slave (fetch port + physical memory port)
module icache (
  input  logic      clk,
  input  logic      reset,
  icache_if.slave   bus
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t       state_reg, state_next;
  logic [7:0]   valid_reg;
  logic [11:0]  miss_reg, miss_next;   // {tag, index} of the line being filled
  logic [8:0]   tag_mem  [8];
  logic [127:0] data_mem [8];

  // Address split; bit 0 is a byte offset inside the 16-bit word.
  logic [8:0] req_tag;
  logic [2:0] req_index;
  logic [2:0] req_word;
  logic       unused_byte_bit;
  assign req_tag         = bus.mem_address[15:7];
  assign req_index       = bus.mem_address[6:4];
  assign req_word        = bus.mem_address[3:1];
  assign unused_byte_bit = bus.mem_address[0];

  logic [2:0] miss_index;
  assign miss_index = miss_reg[2:0];

  // Slice the addressed line into its eight words.
  logic [127:0] line_data;
  logic [15:0]  line_words [8];
  assign line_data = data_mem[req_index];
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_words
      assign line_words[gi] = line_data[16*gi +: 16];
    end
  endgenerate

  logic hit;
  assign hit = bus.mem_read && valid_reg[req_index] && (tag_mem[req_index] == req_tag);

  logic         fill_we;
  logic         resp;
  logic [15:0]  rdata;
  logic         pread;
  logic [15:0]  paddr;

  always_comb begin
    state_next = state_reg;
    miss_next  = miss_reg;
    fill_we    = 1'b0;
    resp       = 1'b0;
    rdata      = 16'h0000;
    pread      = 1'b0;
    paddr      = {bus.mem_address[15:4], 4'b0000};
    case (state_reg)
      IDLE: begin
        if (hit) begin
          resp  = 1'b1;
          rdata = line_words[req_word];
        end else if (bus.mem_read) begin
          miss_next  = {req_tag, req_index};
          state_next = FILL;
        end
      end
      FILL: begin
        pread = 1'b1;
        paddr = {miss_reg, 4'b0000};
        // The fill always completes to the latched line, even if the
        // requester has since dropped or changed its request.
        if (bus.pmem_resp) begin
          fill_we    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      miss_reg  <= 12'h000;
      valid_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      miss_reg  <= miss_next;
      if (fill_we) begin
        valid_reg[miss_index] <= 1'b1;
      end
    end
  end

  // Tag/data storage is not reset: a cleared valid bit hides its content.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[miss_index]  <= miss_reg[11:3];
      data_mem[miss_index] <= bus.pmem_rdata;
    end
  end

  assign bus.mem_resp     = resp;
  assign bus.mem_rdata    = rdata;
  assign bus.pmem_read    = pread;
  assign bus.pmem_address = paddr;

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 lines x 128 bits, direct-mapped, read-only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_address  input  16  fetch address from the instruction fetch stage (PC).
REQ-005 mem_read  input  1  fetch request, held high until mem_resp.
REQ-006 mem_rdata  output  16  instruction word returned to fetch.
REQ-007 mem_resp  output  1  fetch complete; mem_rdata valid this cycle.
REQ-008 pmem_address  output  16  line-aligned physical memory read address.
REQ-009 pmem_read  output  1  line-fill request to physical memory.
REQ-010 pmem_rdata  input  128  line data from physical memory.
REQ-011 pmem_resp  input  1  line data valid; single-cycle pulse.

Function
REQ-012 Address split SHALL be tag = mem_address[15:7], index = mem_address[6:4], word = mem_address[3:1]; mem_address[0] SHALL be ignored.
REQ-013 Per line the block SHALL hold valid (1b), tag (9b), data (128b); word w SHALL be data[16w+15:16w].
REQ-014 FSM SHALL have two states: IDLE and FILL.
REQ-015 IDLE: hit = mem_read && valid[index] && tag[index]==tag; on hit mem_resp=1 and mem_rdata=selected word combinationally, same cycle (zero-wait hit); state stays IDLE.
REQ-016 IDLE: on mem_read && !hit, the block SHALL latch {tag,index} into a miss register and enter FILL next edge; mem_resp=0.
REQ-017 FILL: pmem_read=1 and pmem_address={latched tag, latched index, 4'b0000} every cycle; mem_resp=0.
REQ-018 FILL with pmem_resp=1: on that edge write pmem_rdata into data[latched index], set tag, set valid, return to IDLE; mem_resp stays 0 in this cycle.
REQ-019 Miss latency SHALL be (memory latency in cycles from first pmem_read to pmem_resp) + 1; the request hits in the first IDLE cycle after fill.
REQ-020 Outside FILL, pmem_read SHALL be 0 and pmem_address SHALL be {mem_address[15:4],4'b0000}.
REQ-021 pmem_resp in IDLE SHALL be ignored (no array write, no state change).
REQ-022 mem_read dropped or mem_address changed during FILL: fill SHALL complete to the latched line; in the following IDLE cycle the current inputs are re-evaluated.
REQ-023 A fill to an index holding a valid line SHALL overwrite it (no writeback; read-only).
REQ-024 mem_rdata SHALL be 16'h0000 whenever mem_resp=0.

Reset
REQ-025 reset=1 SHALL immediately (asynchronously) force state=IDLE, all valid bits=0, miss register=0; mem_resp=0, pmem_read=0.
REQ-026 Tag and data arrays need not be reset; valid=0 makes their content unobservable.
REQ-027 Reset asserted during FILL SHALL abandon the fill; a pmem_resp arriving after reset release SHALL be ignored per REQ-021.

Verification
REQ-028 Cold miss: after reset, mem_read=1, mem_address=16'h0102, memory returns line at 16'h0100 with pmem_rdata word1=16'hABCD after 3 cycles -> pmem_read high 3 cycles at 16'h0100, mem_resp=1 with mem_rdata=16'hABCD one cycle after pmem_resp.
REQ-029 Hit: then mem_address=16'h010E -> mem_resp=1 same cycle, mem_rdata=word7 of that line, pmem_read=0.
REQ-030 Conflict: mem_address=16'h0182 (same index 0, tag differs) -> miss, fill from 16'h0180; subsequent 16'h0102 misses again.
REQ-031 Abandoned request: miss on 16'h0200, drop mem_read in cycle 2 of FILL -> fill completes, no mem_resp; later read of 16'h0200 hits with zero wait.
REQ-032 Reset mid-fill: reset pulse while in FILL, pmem_resp pulsed afterwards -> pmem_read=0 from reset, no line installed, next read of that address misses.
REQ-033 Spurious pmem_resp in IDLE with no request -> no state change, valid bits unchanged.
